alu_issue_stage: RTL

Decode-to-execute issue stage that drives the ALU: it accepts decoded-instruction fields from the ID stage and turns each instruction into an `alu_op` code plus the A and B operands. It also produces branch/illegal qualifiers. The result is held in a registered two-entry skid buffer with valid/ready handshakes on both sides. It sits between the register-file read and the combinational ALU, and is the initiator side of the ALU's `a`/`b`/`alu_op` interface.

---
 rtl/my_pkg.sv | 57 +++++
 rtl/alu_issue_stage_if.sv | 36 +++
 rtl/alu_issue_decode.sv | 108 ++++++++++
 rtl/alu_issue_stage.sv | 79 +++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared types and constants for the ALU issue stage: operand width, ALU op
// codes, RV32I opcodes and the issue payload carried through the skid buffer.
package my_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        alu_op_e               op;
        logic                  is_branch;
        logic [2:0]            funct3;
        logic                  illegal;
    } alu_issue_t;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA variants.
    function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID-side and EX-side handshake bundle of the ALU issue stage.
interface alu_issue_stage_if
    import my_pkg::*;
();

    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_rs1_data;
    logic [DATA_WIDTH-1:0] in_rs2_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [3:0]            out_alu_op;
    logic                  out_is_branch;
    logic [2:0]            out_funct3;
    logic                  out_illegal;

    // The issue stage itself.
    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_is_branch,
               out_funct3, out_illegal
    );

    // The surrounding pipeline (ID producer and EX consumer).
    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_is_branch,
               out_funct3, out_illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode of one instruction into ALU op and operands.
module alu_issue_decode
    import my_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  pc,
    input  logic [DATA_WIDTH-1:0]  rs1,
    input  logic [DATA_WIDTH-1:0]  rs2,
    output alu_issue_t             issue
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] shamt;
    logic                  illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = DATA_WIDTH'({{20{instr[31]}}, instr[31:20]});
    assign imm_s  = DATA_WIDTH'({{20{instr[31]}}, instr[31:25], instr[11:7]});
    assign imm_u  = DATA_WIDTH'({instr[31:12], 12'b0});
    assign shamt  = DATA_WIDTH'(instr[24:20]);

    always_comb begin
        issue        = '0;
        issue.op     = ALU_ADD;
        issue.funct3 = funct3;
        illegal      = 1'b0;
        case (opcode)
            OPC_OP: begin
                issue.a = rs1;
                issue.b = rs2;
                if (funct7 == 7'b0000000)
                    issue.op = alu_op_decode(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    issue.op = alu_op_decode(funct3, 1'b1);
                else
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                issue.a = rs1;
                issue.b = imm_i;
                // Shifts take a 5-bit shamt; upper bits are funct7, not immediate.
                if (funct3 == 3'b001) begin
                    issue.b  = shamt;
                    issue.op = ALU_SLL;
                    illegal  = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    issue.b = shamt;
                    if (funct7 == 7'b0000000)
                        issue.op = ALU_SRL;
                    else if (funct7 == 7'b0100000)
                        issue.op = ALU_SRA;
                    else
                        illegal = 1'b1;
                end else begin
                    issue.op = alu_op_decode(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                issue.op = ALU_LUI;
                issue.b  = imm_u;
            end
            OPC_AUIPC: begin
                issue.a = pc;
                issue.b = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                issue.a = pc;
                issue.b = DATA_WIDTH'(4);
            end
            OPC_LOAD: begin
                issue.a = rs1;
                issue.b = imm_i;
            end
            OPC_STORE: begin
                issue.a = rs1;
                issue.b = imm_s;
            end
            OPC_BRANCH: begin
                issue.a         = rs1;
                issue.b         = rs2;
                issue.is_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: issue.op = ALU_SUB;
                    3'b100, 3'b101: issue.op = ALU_SLT;
                    3'b110, 3'b111: issue.op = ALU_SLTU;
                    default:        illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        // Illegal instructions still flow down the pipe but with inert operands.
        if (illegal) begin
            issue.a         = '0;
            issue.b         = '0;
            issue.op        = ALU_ADD;
            issue.is_branch = 1'b0;
        end
        issue.illegal = illegal;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a registered two-entry skid buffer between ID and EX.
module alu_issue_stage
    import my_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_issue_stage_if.slave    bus
);

    alu_issue_t dec;
    alu_issue_t main_q, main_d;
    alu_issue_t skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       accept;
    logic       drain;

    alu_issue_decode u_decode (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .rs1   (bus.in_rs1_data),
        .rs2   (bus.in_rs2_data),
        .issue (dec)
    );

    // in_ready depends only on state, never on out_ready.
    assign bus.in_ready = ~skid_valid_q & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;
    assign drain        = main_valid_q & bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // Skid full implies in_ready=0, so skid and input never compete.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.out_valid     = main_valid_q;
    assign bus.out_a         = main_q.a;
    assign bus.out_b         = main_q.b;
    assign bus.out_alu_op    = main_q.op;
    assign bus.out_is_branch = main_q.is_branch;
    assign bus.out_funct3    = main_q.funct3;
    assign bus.out_illegal   = main_q.illegal;

endmodule
